// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM encoding, FIFO entry layout
// and the bubble value that decode sees when nothing is buffered.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RESP   = 2'd2,
        ST_SQUASH = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-cache read port: one request/grant handshake plus a returning data beat.
interface instr_fetch_if;
    logic        iCacheReq;
    logic [31:0] iCacheAddr;
    logic        iCacheGnt;
    logic        iCacheValid;
    logic [31:0] iCacheReadData;

    modport master (
        output iCacheReq,
        output iCacheAddr,
        input  iCacheGnt,
        input  iCacheValid,
        input  iCacheReadData
    );

    modport slave (
        input  iCacheReq,
        input  iCacheAddr,
        output iCacheGnt,
        output iCacheValid,
        output iCacheReadData
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Small power-of-two FIFO holding fetched words; flush wins over a same-cycle push
// so a redirect can never let a stale word slip in.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  fetch_entry_t     i_entry,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns fetchPC, keeps one I-cache read in flight and buffers returned
// words for decode, honouring decode's freeze and jump redirect.
//
// state     | meaning
// ST_IDLE   | no read in flight; issue once the FIFO has room
// ST_REQ    | request asserted, waiting for grant
// ST_RESP   | granted, waiting for the data beat to push
// ST_SQUASH | granted read became stale after a redirect; drop its data
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        icache,
    input  logic                 freezeIF,
    input  logic                 jFlag,
    input  logic [31:0]          jTarget,
    output logic [31:0]          instr,
    output logic [31:0]          PC_out,
    output logic                 done_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     r_state;
    fetch_state_t     w_next;
    logic [31:0]      r_fetch_pc;
    fetch_entry_t     w_head;
    fetch_entry_t     w_entry;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_redirect;
    logic             w_push;

    assign w_pop      = !w_empty && !freezeIF;
    assign w_redirect = w_pop && jFlag;
    assign w_push     = (r_state == ST_RESP) && icache.iCacheValid && !w_redirect
                        && (!w_full || w_pop);
    assign w_entry    = '{instr: icache.iCacheReadData, pc4: r_fetch_pc + 32'd4};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_fetch_pc <= word_align(jTarget);
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_redirect && (w_count < CNT_W'(FIFO_DEPTH))) w_next = ST_REQ;
            end
            ST_REQ: begin
                // A grant landing with a redirect already issued the old address;
                // its data must be thrown away.
                if (icache.iCacheGnt) w_next = w_redirect ? ST_SQUASH : ST_RESP;
            end
            ST_RESP: begin
                if (icache.iCacheValid)  w_next = w_redirect ? ST_REQ : ST_IDLE;
                else if (w_redirect)     w_next = ST_SQUASH;
            end
            ST_SQUASH: begin
                if (icache.iCacheValid) w_next = ST_REQ;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        icache.iCacheReq  = (r_state == ST_REQ);
        icache.iCacheAddr = word_align(r_fetch_pc);
        done_out          = !w_empty;
        instr             = w_empty ? NOP_INSTR : w_head.instr;
        PC_out            = w_empty ? 32'h0 : w_head.pc4;
    end

endmodule
